posit_op_sequencer: RTL and testbench

- Avalon-MM slave register block. The HPS bridge is the initiator; this block is the responder side of the operand/result interface to the posit arithmetic datapath.
- Replaces free-running PIO exports with an explicit start/busy/done protocol. Operands stay stable for the whole datapath latency, and the result is captured into a register once it is known to be settled.
- Sits in the FPGA top between the HPS lightweight bridge and the posit arithmetic unit (io_num1/io_num2/io_result).

---
 rtl/posit_op_sequencer_if.sv | 33 +++
 rtl/posit_op_sequencer.sv | 163 ++++++++++++++++
 tb/tb_posit_op_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/posit_op_sequencer_if.sv
// ============================================================================
// posit_op_sequencer_if : Avalon-MM slave bus plus posit datapath operand/result
// Revision: 1.0
// ============================================================================
`default_nettype none

interface posit_op_sequencer_if #(
  parameter int WIDTH = 32
);
  logic [2:0]       avs_address;
  logic             avs_write;
  logic [WIDTH-1:0] avs_writedata;
  logic             avs_read;
  logic [WIDTH-1:0] avs_readdata;
  logic             avs_readdatavalid;
  logic [WIDTH-1:0] io_num1;
  logic [WIDTH-1:0] io_num2;
  logic [WIDTH-1:0] io_result;
  logic             irq;

  // Master side covers both the bus initiator and the datapath it feeds.
  modport master (
    output avs_address, avs_write, avs_writedata, avs_read, io_result,
    input  avs_readdata, avs_readdatavalid, io_num1, io_num2, irq
  );

  modport slave (
    input  avs_address, avs_write, avs_writedata, avs_read, io_result,
    output avs_readdata, avs_readdatavalid, io_num1, io_num2, irq
  );
endinterface

`default_nettype wire

// File: rtl/posit_op_sequencer.sv
// ============================================================================
// posit_op_sequencer : start/busy/done register block for the posit datapath.
// Optional macro POSIT_SEQ_IRQ_EN enables the registered completion interrupt.
// Revision: 1.0
// ============================================================================
`default_nettype none

module posit_op_sequencer #(
  parameter int WIDTH     = 32,
  parameter int LATENCY   = 2,
  parameter int CNT_WIDTH = 16
) (
  input  wire logic             clock,
  input  wire logic             reset,
  posit_op_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           wait_cnt_q, wait_cnt_d;
  logic [WIDTH-1:0]     num1_q, num1_d;
  logic [WIDTH-1:0]     num2_q, num2_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 irq_en_q, irq_en_d;
  logic                 done_q, done_d;
  logic                 overrun_q, overrun_d;
  logic [WIDTH-1:0]     rdata_q, rdata_d;
  logic                 rvalid_q, rvalid_d;

  logic             busy;
  logic             wr_num1, wr_num2, wr_ctrl;
  logic             start, clr_done, rd_result;
  logic [WIDTH-1:0] rd_mux;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    num1_d     = num1_q;
    num2_d     = num2_q;
    result_d   = result_q;
    count_d    = count_q;
    irq_en_d   = irq_en_q;
    done_d     = done_q;
    overrun_d  = overrun_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;

    busy      = (state_q != S_IDLE);
    wr_num1   = bus.avs_write && (bus.avs_address == 3'd0);
    wr_num2   = bus.avs_write && (bus.avs_address == 3'd1);
    wr_ctrl   = bus.avs_write && (bus.avs_address == 3'd2);
    start     = wr_ctrl && bus.avs_writedata[0];
    clr_done  = wr_ctrl && bus.avs_writedata[1];
    rd_result = bus.avs_read && (bus.avs_address == 3'd4);

    // Operands are frozen while the datapath is settling.
    if (wr_num1 && !busy) num1_d = bus.avs_writedata;
    if (wr_num2 && !busy) num2_d = bus.avs_writedata;
    if (wr_ctrl)          irq_en_d = bus.avs_writedata[2];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_WAIT;
          wait_cnt_d = 4'(LATENCY);
        end
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q == 4'd1) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_d  = S_IDLE;
        result_d = bus.io_result;
        count_d  = count_q + CNT_WIDTH'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Capture outranks every clearing source.
    if (state_q == S_CAPTURE)
      done_d = 1'b1;
    else if (clr_done || rd_result || (start && !busy))
      done_d = 1'b0;

    if (clr_done)
      overrun_d = 1'b0;
    else if (busy && (start || wr_num1 || wr_num2))
      overrun_d = 1'b1;

    rd_mux = '0;
    case (bus.avs_address)
      3'd0:    rd_mux = num1_q;
      3'd1:    rd_mux = num2_q;
      3'd3:    rd_mux[3:0] = {irq_en_q, overrun_q, done_q, busy};
      3'd4:    rd_mux = result_q;
      3'd5:    rd_mux = WIDTH'(count_q);
      default: rd_mux = '0;
    endcase

    if (bus.avs_read) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      num1_q     <= '0;
      num2_q     <= '0;
      result_q   <= '0;
      count_q    <= '0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      num1_q     <= num1_d;
      num2_q     <= num2_d;
      result_q   <= result_d;
      count_q    <= count_d;
      irq_en_q   <= irq_en_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign bus.io_num1           = num1_q;
  assign bus.io_num2           = num2_q;
  assign bus.avs_readdata      = rdata_q;
  assign bus.avs_readdatavalid = rvalid_q;

`ifdef POSIT_SEQ_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = done_q & irq_en_q;

  always_ff @(posedge clock) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end

  assign bus.irq = irq_q;
`else
  assign bus.irq = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_posit_op_sequencer.sv
// ============================================================================
// tb_posit_op_sequencer : directed self-checking bench with a posit32 adder model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_posit_op_sequencer;

`ifdef POSIT_SEQ_IRQ_EN
  localparam logic [31:0] IRQ_EXP = 32'd1;
`else
  localparam logic [31:0] IRQ_EXP = 32'd0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] dp1 = '0;
  logic [31:0] dp2 = '0;
  logic [31:0] rd;

  always #5 clock = ~clock;

  posit_op_sequencer_if #(.WIDTH(32)) bus ();

  posit_op_sequencer #(
    .WIDTH(32), .LATENCY(2), .CNT_WIDTH(16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Posit32 es=2 value decode (exact for the short patterns used here).
  function automatic real p_decode(input logic [31:0] p);
    logic [31:0] t;
    logic        r;
    int          m, k, e, s;
    real         v;
    if (p == 32'd0) return 0.0;
    t = p[31] ? -p : p;
    t = t << 1;
    r = t[31];
    m = 0;
    while (m < 31 && t[31] == r) begin
      m++;
      t = t << 1;
    end
    t = t << 1;
    k = r ? m - 1 : -m;
    e = int'(t[31:30]);
    t = t << 2;
    v = 1.0 + real'(longint'({32'd0, t})) / 4294967296.0;
    s = 4 * k + e;
    while (s > 0) begin v = v * 2.0; s--; end
    while (s < 0) begin v = v / 2.0; s++; end
    return p[31] ? -v : v;
  endfunction

  function automatic logic [31:0] p_encode(input real v);
    logic [31:0] p;
    bit          q[$];
    int          s, k, e;
    real         f;
    if (v == 0.0) return 32'd0;
    f = v;
    s = 0;
    while (f >= 2.0) begin f = f / 2.0; s++; end
    while (f < 1.0)  begin f = f * 2.0; s--; end
    k = (s >= 0) ? s / 4 : -((-s + 3) / 4);
    e = s - 4 * k;
    if (k >= 0) begin
      for (int i = 0; i <= k; i++) q.push_back(1'b1);
      q.push_back(1'b0);
    end else begin
      for (int i = 0; i < -k; i++) q.push_back(1'b0);
      q.push_back(1'b1);
    end
    q.push_back(e[1]);
    q.push_back(e[0]);
    f = f - 1.0;
    for (int i = 0; i < 31; i++) begin
      f = f * 2.0;
      if (f >= 1.0) begin q.push_back(1'b1); f = f - 1.0; end
      else          q.push_back(1'b0);
    end
    p = '0;
    for (int i = 0; i < 31 && i < q.size(); i++) p[30-i] = q[i];
    return p;
  endfunction

  // Two-stage datapath model: result settles two cycles after operands.
  always @(posedge clock) begin
    dp1 <= p_encode(p_decode(bus.io_num1) + p_decode(bus.io_num2));
    dp2 <= dp1;
  end
  assign bus.io_result = dp2;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus.avs_address   = a;
    bus.avs_writedata = d;
    bus.avs_write     = 1'b1;
    tick();
    bus.avs_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    tick();
    bus.avs_read    = 1'b0;
    check_eq("rdvalid", {31'd0, bus.avs_readdatavalid}, 32'd1);
    d = bus.avs_readdata;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check_eq(tag, d, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.avs_address   = '0;
    bus.avs_write     = 1'b0;
    bus.avs_writedata = '0;
    bus.avs_read      = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    check_eq("irq_rst", {31'd0, bus.irq}, 32'd0);
    check_eq("rdvalid_rst", {31'd0, bus.avs_readdatavalid}, 32'd0);
    for (int a = 0; a < 6; a++) rd_chk("reset_rd", 3'(a), 32'd0);
    tick();
    check_eq("rdvalid_idle", {31'd0, bus.avs_readdatavalid}, 32'd0);

    // 1.0 + 1.0
    bus_write(3'd0, 32'h4000_0000);
    bus_write(3'd1, 32'h4000_0000);
    rd_chk("num1_rb", 3'd0, 32'h4000_0000);
    bus_write(3'd2, 32'h1);
    rd_chk("busy_c1", 3'd3, 32'h1);
    rd_chk("busy_c2", 3'd3, 32'h1);
    tick();
    rd_chk("done_st", 3'd3, 32'h2);
    rd_chk("count1", 3'd5, 32'd1);
    rd_chk("ctrl_rd0", 3'd2, 32'd0);
    rd_chk("result1", 3'd4, 32'h4800_0000);
    rd_chk("st_after_rd", 3'd3, 32'h0);

    // Writes while busy are dropped and flag overrun
    bus_write(3'd2, 32'h1);
    bus_write(3'd0, 32'h4800_0000);
    check_eq("num1_frozen", bus.io_num1, 32'h4000_0000);
    bus_write(3'd2, 32'h1);
    tick();
    rd_chk("overrun_st", 3'd3, 32'h6);
    rd_chk("result2", 3'd4, 32'h4800_0000);
    rd_chk("count2", 3'd5, 32'd2);
    check_eq("num1_still", bus.io_num1, 32'h4000_0000);
    bus_write(3'd2, 32'h2);
    rd_chk("clr_st", 3'd3, 32'h0);

    // RESULT read on the capture edge returns the old value
    bus_write(3'd0, 32'h4800_0000);
    bus_write(3'd2, 32'h1);
    tick();
    tick();
    rd_chk("res_old", 3'd4, 32'h4800_0000);
    rd_chk("done_kept", 3'd3, 32'h2);
    rd_chk("res_new", 3'd4, 32'h4C00_0000);
    rd_chk("done_clr", 3'd3, 32'h0);

    // Reset mid-operation
    bus_write(3'd2, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (4) tick();
    rd_chk("rst_st", 3'd3, 32'h0);
    rd_chk("rst_cnt", 3'd5, 32'd0);
    rd_chk("rst_res", 3'd4, 32'd0);
    check_eq("rst_num1", bus.io_num1, 32'd0);

    // 1.0 + 3.0 after the reset
    bus_write(3'd0, 32'h4000_0000);
    bus_write(3'd1, 32'h4C00_0000);
    bus_write(3'd2, 32'h1);
    tick();
    tick();
    tick();
    rd_chk("post_rst_st", 3'd3, 32'h2);
    rd_chk("post_rst_cnt", 3'd5, 32'd1);

    // START with IRQ_EN while DONE=1; DONE clears on the accepting edge
    bus_write(3'd2, 32'h5);
    rd_chk("start_done", 3'd3, 32'h9);
    check_eq("irq_busy", {31'd0, bus.irq}, 32'd0);
    tick();
    tick();
    check_eq("irq_capture", {31'd0, bus.irq}, 32'd0);
    tick();
    check_eq("irq_rise", {31'd0, bus.irq}, IRQ_EXP);
    rd_chk("irq_st", 3'd3, 32'hA);
    rd_chk("result4", 3'd4, 32'h5000_0000);
    check_eq("irq_hold", {31'd0, bus.irq}, IRQ_EXP);
    tick();
    check_eq("irq_fall", {31'd0, bus.irq}, 32'd0);
    rd_chk("irq_en_st", 3'd3, 32'h8);
    bus_write(3'd2, 32'h0);
    rd_chk("irq_en_off", 3'd3, 32'h0);

    // Unmapped addresses
    bus_write(3'd6, 32'hFFFF_FFFF);
    rd_chk("addr6", 3'd6, 32'd0);
    rd_chk("addr7", 3'd7, 32'd0);
    rd_chk("num1_keep", 3'd0, 32'h4000_0000);
    rd_chk("count_final", 3'd5, 32'd2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
